writeback_stage: RTL

//  Registered MEM/WB pipeline stage and final result selection for the core.

---
 rtl/writeback_stage_pkg.sv | 33 +++
 rtl/writeback_stage_if.sv | 43 ++++
 rtl/writeback_stage_load_extender.sv | 53 +++++
 rtl/writeback_stage.sv | 102 ++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared types for the MEM/WB stage: result-select and load-size encodings,
// plus the byte-offset alignment mask used to detect misaligned loads.
package writeback_stage_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      RESULT_ALU = 2'd0,
      RESULT_MEM = 2'd1,
      RESULT_PC  = 2'd2,
      RESULT_IMM = 2'd3
   } result_sel_e;

   typedef enum logic [1:0] {
      LS_B = 2'd0,
      LS_H = 2'd1,
      LS_W = 2'd2,
      LS_D = 2'd3
   } load_size_e;

   // Offset bits that must be zero for a naturally aligned access of this size.
   function automatic logic [2:0] size_mask(load_size_e size);
      logic [2:0] mask;
      case (size)
         LS_B:    mask = 3'b000;
         LS_H:    mask = 3'b001;
         LS_W:    mask = 3'b011;
         default: mask = 3'b111;
      endcase
      return mask;
   endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// MEM-to-WB bundle: MEM-stage results and hazard controls in, registered
// write-back / bypass signals and the retire counter out.
interface writeback_stage_if
   import writeback_stage_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int REG_ADDR_W   = 5,
   parameter int RETIRE_CNT_W = 32
);
   logic                    mem_valid;
   logic [XLEN-1:0]         mem_alu_result;
   logic [XLEN-1:0]         mem_read_data;
   logic [XLEN-1:0]         mem_pc4;
   logic [XLEN-1:0]         mem_imm;
   result_sel_e             mem_result_sel;
   load_size_e              mem_load_size;
   logic                    mem_load_unsigned;
   logic [REG_ADDR_W-1:0]   mem_a3;
   logic                    mem_regw;
   logic                    stall;
   logic                    flush;

   logic                    wb_valid;
   logic [XLEN-1:0]         wb_result;
   logic [REG_ADDR_W-1:0]   wb_a3;
   logic                    wb_regw;
   logic                    wb_misalign;
   logic [RETIRE_CNT_W-1:0] retired_count;

   modport master (
      output mem_valid, mem_alu_result, mem_read_data, mem_pc4, mem_imm,
             mem_result_sel, mem_load_size, mem_load_unsigned, mem_a3, mem_regw,
             stall, flush,
      input  wb_valid, wb_result, wb_a3, wb_regw, wb_misalign, retired_count
   );

   modport slave (
      input  mem_valid, mem_alu_result, mem_read_data, mem_pc4, mem_imm,
             mem_result_sel, mem_load_size, mem_load_unsigned, mem_a3, mem_regw,
             stall, flush,
      output wb_valid, wb_result, wb_a3, wb_regw, wb_misalign, retired_count
   );
endinterface

// File: rtl/writeback_stage_load_extender.sv
// Combinational load extractor: picks the addressed byte/half/word out of the
// aligned memory word, sign- or zero-extends it, and flags misalignment.
module writeback_stage_load_extender
   import writeback_stage_pkg::*;
#(
   parameter int XLEN  = XLEN_DEFAULT,
   parameter int OFF_W = $clog2(XLEN / 8)
) (
   input  logic [XLEN-1:0]  raw_i,
   input  logic [OFF_W-1:0] offset_i,
   input  load_size_e       size_i,
   input  logic             unsigned_i,
   output logic [XLEN-1:0]  data_o,
   output logic             misalign_o
);

   load_size_e      effSize;
   logic [XLEN-1:0] shifted;
   logic [XLEN-1:0] lowMask;
   logic            signBit;

   // Doubleword loads do not exist on a 32-bit datapath and fall back to word.
   always_comb begin
      effSize = size_i;
      if (XLEN == 32 && size_i == LS_D) begin
         effSize = LS_W;
      end
      shifted = raw_i >> {offset_i, 3'b000};
      lowMask = '1;
      signBit = 1'b0;
      case (effSize)
         LS_B: begin
            lowMask = XLEN'(8'hFF);
            signBit = shifted[7];
         end
         LS_H: begin
            lowMask = XLEN'(16'hFFFF);
            signBit = shifted[15];
         end
         LS_W: begin
            lowMask = XLEN'(32'hFFFF_FFFF);
            signBit = shifted[31];
         end
         default: begin
            lowMask = '1;
            signBit = 1'b0;
         end
      endcase
      data_o     = (shifted & lowMask) | ((signBit && !unsigned_i) ? ~lowMask : '0);
      misalign_o = (offset_i & OFF_W'(size_mask(effSize))) != '0;
   end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline register with result selection, load extension, misalign
// detection and a retired-instruction counter; every output is registered.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int XLEN         = XLEN_DEFAULT,
   parameter int REG_ADDR_W   = 5,
   parameter int RETIRE_CNT_W = 32
) (
   input logic              clk,
   input logic              rst,
   writeback_stage_if.slave bus
);

   localparam int OFF_W = $clog2(XLEN / 8);

   logic [XLEN-1:0]         loadData;
   logic                    loadMisalign;
   logic [XLEN-1:0]         selResult;
   logic                    isMisalign;

   logic                    valid_q, valid_d;
   logic [XLEN-1:0]         result_q, result_d;
   logic [REG_ADDR_W-1:0]   a3_q, a3_d;
   logic                    regw_q, regw_d;
   logic                    misalign_q, misalign_d;
   logic [RETIRE_CNT_W-1:0] count_q, count_d;

   writeback_stage_load_extender #(
      .XLEN  (XLEN),
      .OFF_W (OFF_W)
   ) u_load_extender (
      .raw_i      (bus.mem_read_data),
      .offset_i   (bus.mem_alu_result[OFF_W-1:0]),
      .size_i     (bus.mem_load_size),
      .unsigned_i (bus.mem_load_unsigned),
      .data_o     (loadData),
      .misalign_o (loadMisalign)
   );

   // Flush beats stall beats capture; the counter retires whatever WB held
   // before this edge unless the stage is stalled.
   always_comb begin
      case (bus.mem_result_sel)
         RESULT_MEM: selResult = loadData;
         RESULT_PC:  selResult = bus.mem_pc4;
         RESULT_IMM: selResult = bus.mem_imm;
         default:    selResult = bus.mem_alu_result;
      endcase
      isMisalign = bus.mem_valid && (bus.mem_result_sel == RESULT_MEM) && loadMisalign;

      valid_d    = valid_q;
      result_d   = result_q;
      a3_d       = a3_q;
      regw_d     = regw_q;
      misalign_d = misalign_q;
      if (bus.flush) begin
         valid_d    = 1'b0;
         result_d   = '0;
         a3_d       = '0;
         regw_d     = 1'b0;
         misalign_d = 1'b0;
      end else if (!bus.stall) begin
         valid_d    = bus.mem_valid;
         result_d   = isMisalign ? '0 : selResult;
         a3_d       = bus.mem_a3;
         regw_d     = bus.mem_valid && bus.mem_regw && (bus.mem_a3 != '0) && !isMisalign;
         misalign_d = isMisalign;
      end

      count_d = count_q;
      if (valid_q && !bus.stall) begin
         count_d = count_q + RETIRE_CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q    <= 1'b0;
         result_q   <= '0;
         a3_q       <= '0;
         regw_q     <= 1'b0;
         misalign_q <= 1'b0;
         count_q    <= '0;
      end else begin
         valid_q    <= valid_d;
         result_q   <= result_d;
         a3_q       <= a3_d;
         regw_q     <= regw_d;
         misalign_q <= misalign_d;
         count_q    <= count_d;
      end
   end

   assign bus.wb_valid      = valid_q;
   assign bus.wb_result     = result_q;
   assign bus.wb_a3         = a3_q;
   assign bus.wb_regw       = regw_q;
   assign bus.wb_misalign   = misalign_q;
   assign bus.retired_count = count_q;

endmodule
